fetch_sequencer: RTL



---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: FSM encoding, reset vector, opcode/func constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } fsm_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] DEF_PC_STEP      = 32'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;

    // Jump targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port between fetch_sequencer and the instruction RAM.
interface fetch_sequencer_if;

    logic [31:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_readdata;
    logic        instr_waitrequest;

    modport master (
        output instr_address,
        output instr_read,
        input  instr_readdata,
        input  instr_waitrequest
    );

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_readdata,
        output instr_waitrequest
    );

endinterface

// File: rtl/fetch_sequencer.sv
// PC / IR / phase sequencer feeding the main decoder.
// Define FETCH_DELAY_SLOT_EN for a one-instruction branch delay slot.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] PC_STEP      = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master imem,
    output logic [5:0]        instruction_opcode,
    output logic [5:0]        func_code,
    output logic [31:0]       ir,
    output logic              state,
    input  logic              branch,
    input  logic [31:0]       branch_target,
    input  logic              halt,
    output logic [31:0]       pc,
    output logic              active
);

    localparam logic [1:0] S_FETCH  = FETCH;
    localparam logic [1:0] S_EXEC   = EXEC;
    localparam logic [1:0] S_HALTED = HALTED;

    logic [1:0]  fsm;
    logic [31:0] pc_seq;
    logic [31:0] next_pc;

    assign pc_seq = pc + PC_STEP;

`ifdef FETCH_DELAY_SLOT_EN
    logic        pending_valid;
    logic [31:0] pending_target;

    // A branch in the delay slot is dropped; halt discards the redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_valid  <= 1'b0;
            pending_target <= '0;
        end else if (fsm == S_EXEC) begin
            if (halt) begin
                pending_valid <= 1'b0;
            end else if (pending_valid) begin
                pending_valid <= 1'b0;
            end else if (branch) begin
                pending_valid  <= 1'b1;
                pending_target <= word_align(branch_target);
            end
        end
    end

    always_comb begin
        next_pc = pc_seq;
        if (pending_valid) begin
            next_pc = pending_target;
        end
    end
`else
    always_comb begin
        next_pc = pc_seq;
        if (branch) begin
            next_pc = word_align(branch_target);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm    <= S_FETCH;
            pc     <= RESET_VECTOR;
            ir     <= '0;
            active <= 1'b1;
        end else begin
            unique case (fsm)
                S_FETCH: begin
                    if (!imem.instr_waitrequest) begin
                        ir  <= imem.instr_readdata;
                        fsm <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (halt) begin
                        fsm    <= S_HALTED;
                        active <= 1'b0;
                    end else begin
                        fsm <= S_FETCH;
                        pc  <= next_pc;
                    end
                end
                S_HALTED: begin
                    fsm <= S_HALTED;
                end
                default: begin
                    fsm    <= S_HALTED;
                    active <= 1'b0;
                end
            endcase
        end
    end

    assign imem.instr_address = pc;
    assign imem.instr_read    = (fsm == S_FETCH);
    assign state              = (fsm == S_EXEC);
    assign instruction_opcode = ir[31:26];
    assign func_code          = ir[5:0];

endmodule
